// File: rtl/fpu_pkg.sv
// Shared types for the fp16 FPU initiator: operand, opcode, exception flags and arbiter state.
package fpu_pkg;

    typedef logic [15:0] fp16_t;

    typedef enum logic [1:0] {
        FPU_ADD = 2'b00,
        FPU_SUB = 2'b01,
        FPU_MUL = 2'b10,
        FPU_DIV = 2'b11
    } fpu_op_e;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } fpu_flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer,
// pointer moves past the winner whenever a grant is taken while enabled.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_idx = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

    assign ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (enable && found) begin
            ptr_q <= ptr_next;
        end
    end

endmodule

// File: rtl/fpu_client_arbiter.sv
// Initiator side of the shared fp16 FPU: round-robin client arbitration, operand issue,
// tagged response capture. Sticky exception register built only with FPU_STICKY_FLAGS_EN.
module fpu_client_arbiter
    import fpu_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 2,
    parameter int unsigned TAG_W = 4,
    localparam int unsigned IDX_W = $clog2(NUM_CLIENTS)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CLIENTS-1:0]     req_valid,
    output logic [NUM_CLIENTS-1:0]     req_ready,
    input  logic [NUM_CLIENTS*16-1:0]  req_opA,
    input  logic [NUM_CLIENTS*16-1:0]  req_opB,
    input  logic [NUM_CLIENTS*2-1:0]   req_op,
    input  logic [NUM_CLIENTS*TAG_W-1:0] req_tag,
    output logic [15:0]                fpu_opA,
    output logic [15:0]                fpu_opB,
    output logic [1:0]                 fpu_op,
    input  logic [15:0]                fpu_result,
    input  logic                       fpu_overflow,
    input  logic                       fpu_underflow,
    input  logic                       fpu_inexact,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [15:0]                rsp_result,
    output logic [IDX_W-1:0]           rsp_client,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic [2:0]                 rsp_flags,
    output logic [2:0]                 sticky_flags,
    input  logic                       sticky_clear
);

    if (NUM_CLIENTS < 2 || NUM_CLIENTS > 8) begin : g_bad_cfg
        $error("fpu_client_arbiter: NUM_CLIENTS must be in 2..8");
    end

    arb_state_e state_q, state_d;
    logic                   accept;
    logic                   handshake;
    logic [NUM_CLIENTS-1:0] grant;
    logic [IDX_W-1:0]       grant_idx;

    fp16_t            issue_a_q, issue_b_q;
    fpu_op_e          issue_op_q;
    logic [TAG_W-1:0] issue_tag_q;
    logic [IDX_W-1:0] issue_client_q;

    fp16_t            rsp_result_q;
    logic [IDX_W-1:0] rsp_client_q;
    logic [TAG_W-1:0] rsp_tag_q;
    fpu_flags_t       rsp_flags_q;
    fpu_flags_t       cap_flags;

    // A finished response and a new grant may share one cycle, giving 1 op per 2 cycles.
    assign accept    = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
    assign handshake = accept && (|req_valid);
    assign req_ready = accept ? grant : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_CLIENTS)
    ) u_rr_arbiter (
        .clock     (clock),
        .reset     (reset),
        .req       (req_valid),
        .enable    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (handshake) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = handshake ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cap_flags = '{overflow: fpu_overflow, underflow: fpu_underflow, inexact: fpu_inexact};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            issue_a_q      <= '0;
            issue_b_q      <= '0;
            issue_op_q     <= FPU_ADD;
            issue_tag_q    <= '0;
            issue_client_q <= '0;
            rsp_result_q   <= '0;
            rsp_client_q   <= '0;
            rsp_tag_q      <= '0;
            rsp_flags_q    <= '0;
        end else begin
            state_q <= state_d;
            if (handshake) begin
                issue_a_q      <= req_opA[32'(grant_idx)*16 +: 16];
                issue_b_q      <= req_opB[32'(grant_idx)*16 +: 16];
                issue_op_q     <= fpu_op_e'(req_op[32'(grant_idx)*2 +: 2]);
                issue_tag_q    <= req_tag[32'(grant_idx)*TAG_W +: TAG_W];
                issue_client_q <= grant_idx;
            end
            if (state_q == EXEC) begin
                rsp_result_q <= fpu_result;
                rsp_client_q <= issue_client_q;
                rsp_tag_q    <= issue_tag_q;
                rsp_flags_q  <= cap_flags;
            end
        end
    end

    assign fpu_opA    = issue_a_q;
    assign fpu_opB    = issue_b_q;
    assign fpu_op     = issue_op_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_result = rsp_result_q;
    assign rsp_client = rsp_client_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_flags  = rsp_flags_q;

`ifdef FPU_STICKY_FLAGS_EN
    logic [2:0] sticky_q;

    // A clear coinciding with a capture still keeps the flags of that capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            sticky_q <= '0;
        end else if (state_q == EXEC) begin
            sticky_q <= (sticky_clear ? 3'b000 : sticky_q) | cap_flags;
        end else if (sticky_clear) begin
            sticky_q <= '0;
        end
    end

    assign sticky_flags = sticky_q;
`else
    logic unused_sticky_clear;
    assign unused_sticky_clear = sticky_clear;
    assign sticky_flags        = 3'b000;
`endif

endmodule

// File: tb/tb_fpu_client_arbiter.sv
// Scoreboard bench for fpu_client_arbiter with a stub FPU; follows FPU_STICKY_FLAGS_EN.
module tb_fpu_client_arbiter;

    localparam int N  = 2;
    localparam int TW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [N*16-1:0] req_opA, req_opB;
    logic [N*2-1:0]  req_op;
    logic [N*TW-1:0] req_tag;
    logic [15:0]   fpu_opA, fpu_opB, fpu_result;
    logic [1:0]    fpu_op;
    logic          fpu_overflow, fpu_underflow, fpu_inexact;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [15:0]   rsp_result;
    logic          rsp_client;
    logic [TW-1:0] rsp_tag;
    logic [2:0]    rsp_flags, sticky_flags;
    logic          sticky_clear = 1'b0;

    logic [15:0]   c_opA [N];
    logic [15:0]   c_opB [N];
    logic [1:0]    c_op  [N];
    logic [TW-1:0] c_tag [N];

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign req_opA[i*16 +: 16] = c_opA[i];
        assign req_opB[i*16 +: 16] = c_opB[i];
        assign req_op[i*2 +: 2]    = c_op[i];
        assign req_tag[i*TW +: TW] = c_tag[i];
    end

    always #5 clock = ~clock;

    // Stub FPU: a few real fp16 results, otherwise a deterministic scramble.
    function automatic logic [18:0] fake_fpu(logic [15:0] a, logic [15:0] b, logic [1:0] op);
        if (a == 16'h3C00 && b == 16'h4000 && op == 2'b00) return {16'h4200, 3'b000};
        if (a == 16'h7BFF && b == 16'h4000 && op == 2'b10) return {16'h7C00, 3'b100};
        if (a == 16'h3C00 && b == 16'h4200 && op == 2'b11) return {16'h3555, 3'b001};
        return {a ^ {b[7:0], b[15:8]} ^ {14'd0, op}, a[0] & b[0], 1'b0, a[1] ^ b[1]};
    endfunction

    assign {fpu_result, fpu_overflow, fpu_underflow, fpu_inexact} =
        fake_fpu(fpu_opA, fpu_opB, fpu_op);

    fpu_client_arbiter #(
        .NUM_CLIENTS (N),
        .TAG_W       (TW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_opA       (req_opA),
        .req_opB       (req_opB),
        .req_op        (req_op),
        .req_tag       (req_tag),
        .fpu_opA       (fpu_opA),
        .fpu_opB       (fpu_opB),
        .fpu_op        (fpu_op),
        .fpu_result    (fpu_result),
        .fpu_overflow  (fpu_overflow),
        .fpu_underflow (fpu_underflow),
        .fpu_inexact   (fpu_inexact),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_client    (rsp_client),
        .rsp_tag       (rsp_tag),
        .rsp_flags     (rsp_flags),
        .sticky_flags  (sticky_flags),
        .sticky_clear  (sticky_clear)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    typedef struct packed {
        logic [15:0]   res;
        logic          client;
        logic [TW-1:0] tag;
        logic [2:0]    flags;
    } exp_t;

    exp_t sb[$];
    int   dut_grants[$];

    // Reference model state: 0 idle, 1 exec, 2 resp.
    int          m_state = 0;
    int          m_ptr = 0;
    logic [15:0] m_a = '0, m_b = '0;
    logic [1:0]  m_op = '0;
    logic [2:0]  m_flags = '0, m_sticky = '0;

    always @(negedge clock) begin
        logic [N-1:0] exp_ready;
        logic         win;
        int           g, c;
        logic [18:0]  f;
        exp_t         e;

        check_eq("rsp_valid", rsp_valid, m_state == 2);
        if (m_state == 2) begin
            check_eq("sb_size", sb.size(), 1);
            if (sb.size() > 0) begin
                check_eq("rsp_result", rsp_result, sb[0].res);
                check_eq("rsp_client", rsp_client, sb[0].client);
                check_eq("rsp_tag", rsp_tag, sb[0].tag);
                check_eq("rsp_flags", rsp_flags, sb[0].flags);
            end
        end
        check_eq("fpu_opA", fpu_opA, m_a);
        check_eq("fpu_opB", fpu_opB, m_b);
        check_eq("fpu_op", fpu_op, m_op);
        check_eq("sticky_flags", sticky_flags, m_sticky);

        win = (m_state == 0) || (m_state == 2 && rsp_ready);
        g = -1;
        for (int i = 0; i < N; i++) begin
            c = (m_ptr + i) % N;
            if (g < 0 && req_valid[c]) g = c;
        end
        exp_ready = (win && g >= 0) ? N'(1 << g) : '0;
        check_eq("req_ready", req_ready, exp_ready);

        if (!reset) begin
            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_ready[i]) dut_grants.push_back(i);
        end

        if (reset) begin
            m_state = 0; m_ptr = 0; m_a = '0; m_b = '0; m_op = '0; m_sticky = '0;
            sb.delete();
        end else begin
`ifdef FPU_STICKY_FLAGS_EN
            if (m_state == 1) m_sticky = (sticky_clear ? 3'b000 : m_sticky) | m_flags;
            else if (sticky_clear) m_sticky = 3'b000;
`endif
            if (m_state == 2 && rsp_ready && sb.size() > 0) void'(sb.pop_front());
            if (win && g >= 0) begin
                f = fake_fpu(c_opA[g], c_opB[g], c_op[g]);
                e.res = f[18:3]; e.client = g[0]; e.tag = c_tag[g]; e.flags = f[2:0];
                sb.push_back(e);
                m_flags = f[2:0];
                m_a = c_opA[g]; m_b = c_opB[g]; m_op = c_op[g];
                m_ptr = (g + 1) % N;
                m_state = 1;
            end else if (m_state == 1) m_state = 2;
            else if (m_state == 2 && rsp_ready) m_state = 0;
        end
    end

    task automatic issue(input int c, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic [TW-1:0] tag);
        logic got;
        c_opA[c] = a; c_opB[c] = b; c_op[c] = op; c_tag[c] = tag;
        req_valid[c] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (req_ready[c]) begin got = 1'b1; break; end
        end
        check_eq("accept", got, 1);
        @(posedge clock); #1;
        req_valid[c] = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_fpu_opA"}, fpu_opA, 0);
        check_eq({tag, "_fpu_opB"}, fpu_opB, 0);
        check_eq({tag, "_fpu_op"}, fpu_op, 0);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
        check_eq({tag, "_rsp_result"}, rsp_result, 0);
        check_eq({tag, "_rsp_client"}, rsp_client, 0);
        check_eq({tag, "_rsp_tag"}, rsp_tag, 0);
        check_eq({tag, "_rsp_flags"}, rsp_flags, 0);
        check_eq({tag, "_sticky"}, sticky_flags, 0);
    endtask

`ifdef FPU_STICKY_FLAGS_EN
    localparam logic [2:0] STICKY_OVF = 3'b100;
    localparam logic [2:0] STICKY_INX = 3'b001;
`else
    localparam logic [2:0] STICKY_OVF = 3'b000;
    localparam logic [2:0] STICKY_INX = 3'b000;
`endif

    logic [18:0] bp_exp;

    initial begin
        for (int i = 0; i < N; i++) begin
            c_opA[i] = '0; c_opB[i] = '0; c_op[i] = '0; c_tag[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_zero_outputs("reset");

        // Single add, exact two-cycle latency
        @(posedge clock); #1;
        issue(0, 16'h3C00, 16'h4000, 2'b00, 4'd5);
        @(negedge clock);
        check_eq("add_lat1", rsp_valid, 0);
        @(negedge clock);
        check_eq("add_lat2", rsp_valid, 1);
        check_eq("add_result", rsp_result, 16'h4200);
        check_eq("add_client", rsp_client, 0);
        check_eq("add_tag", rsp_tag, 5);
        check_eq("add_flags", rsp_flags, 3'b000);
        repeat (2) @(posedge clock); #1;

        // Overflow, clear in idle, clear coincident with an inexact capture
        issue(0, 16'h7BFF, 16'h4000, 2'b10, 4'd3);
        repeat (2) @(negedge clock);
        check_eq("ovf_flags", rsp_flags, 3'b100);
        @(negedge clock);
        check_eq("ovf_sticky", sticky_flags, STICKY_OVF);
        @(posedge clock); #1 sticky_clear = 1'b1;
        @(posedge clock); #1 sticky_clear = 1'b0;
        @(negedge clock);
        check_eq("clr_idle", sticky_flags, 0);
        @(posedge clock); #1;
        issue(0, 16'h7BFF, 16'h4000, 2'b10, 4'd4);
        repeat (3) @(negedge clock);
        check_eq("ovf_sticky2", sticky_flags, STICKY_OVF);
        @(posedge clock); #1;
        issue(1, 16'h3C00, 16'h4200, 2'b11, 4'd9);
        sticky_clear = 1'b1;
        @(posedge clock); #1 sticky_clear = 1'b0;
        @(negedge clock);
        check_eq("clr_capture", sticky_flags, STICKY_INX);
        check_eq("inx_flags", rsp_flags, 3'b001);
        repeat (2) @(posedge clock); #1;

        // Backpressure with client1 waiting
        rsp_ready = 1'b0;
        bp_exp = fake_fpu(16'h1234, 16'h5678, 2'b00);
        issue(0, 16'h1234, 16'h5678, 2'b00, 4'd7);
        c_opA[1] = 16'h0A0B; c_opB[1] = 16'h0C0D; c_op[1] = 2'b01; c_tag[1] = 4'd12;
        req_valid[1] = 1'b1;
        repeat (2) @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check_eq("bp_valid", rsp_valid, 1);
            check_eq("bp_result", rsp_result, bp_exp[18:3]);
            check_eq("bp_tag", rsp_tag, 7);
            check_eq("bp_ready", req_ready, 2'b00);
        end
        @(posedge clock); #1 rsp_ready = 1'b1;
        @(negedge clock);
        check_eq("bp_release_ready", req_ready, 2'b10);
        check_eq("bp_release_valid", rsp_valid, 1);
        @(posedge clock); #1 req_valid[1] = 1'b0;
        @(negedge clock);
        check_eq("bp_next_lat1", rsp_valid, 0);
        @(negedge clock);
        check_eq("bp_next_valid", rsp_valid, 1);
        check_eq("bp_next_client", rsp_client, 1);
        check_eq("bp_next_tag", rsp_tag, 12);
        repeat (2) @(posedge clock); #1;

        // Contention from reset
        reset = 1'b1;
        c_opA[0] = 16'h1111; c_opB[0] = 16'h2222; c_op[0] = 2'b00; c_tag[0] = 4'd1;
        c_opA[1] = 16'h3333; c_opB[1] = 16'h4444; c_op[1] = 2'b10; c_tag[1] = 4'd2;
        req_valid = 2'b11;
        repeat (2) @(posedge clock); #1;
        dut_grants.delete();
        reset = 1'b0;
        for (int k = 0; k < 40 && dut_grants.size() < 4; k++) @(negedge clock);
        check_eq("cont_count", dut_grants.size() >= 4, 1);
        if (dut_grants.size() >= 4) begin
            check_eq("cont_g0", dut_grants[0], 0);
            check_eq("cont_g1", dut_grants[1], 1);
            check_eq("cont_g2", dut_grants[2], 0);
            check_eq("cont_g3", dut_grants[3], 1);
        end
        @(posedge clock); #1 req_valid = 2'b00;
        repeat (4) @(posedge clock); #1;

        // Reset mid-EXEC
        issue(0, 16'h5555, 16'h6666, 2'b01, 4'd8);
        reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check_zero_outputs("rst_exec");
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check_eq("rst_no_rsp", rsp_valid, 0);
        end
        @(posedge clock); #1;
        dut_grants.delete();
        req_valid = 2'b11;
        for (int k = 0; k < 10 && dut_grants.size() < 1; k++) @(negedge clock);
        check_eq("rst_ptr_count", dut_grants.size(), 1);
        if (dut_grants.size() >= 1) check_eq("rst_ptr_grant", dut_grants[0], 0);
        @(posedge clock); #1 req_valid = 2'b00;
        repeat (4) @(posedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fpu_client_arbiter.md
Name: fpu_client_arbiter

Overview:
- Initiator side of the shared fp16 FPU in a GraphPulse PE.
- Arbitrates round-robin among NUM_CLIENTS requesters (delta-update and accumulate paths) using valid/ready handshakes.
- Registers the winning operands and drives the combinational FPU's opA/opB/op inputs.
- Captures result plus overflow/underflow/inexact, returns a tagged response, and keeps a sticky exception register.

Parameters:
- NUM_CLIENTS, 2, number of requesters; 2..8.
- TAG_W, 4, width of the opaque request tag echoed in the response.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_CLIENTS  per-client request valid.
- req_ready  out  NUM_CLIENTS  per-client accept; one-hot or zero.
- req_opA  in  NUM_CLIENTS x 16  fp16 operand A.
- req_opB  in  NUM_CLIENTS x 16  fp16 operand B.
- req_op  in  NUM_CLIENTS x 2  00 add, 01 sub, 10 mul, 11 div.
- req_tag  in  NUM_CLIENTS x TAG_W  request tag.
- fpu_opA, fpu_opB  out  16  to FPU.
- fpu_op  out  2  to FPU.
- fpu_result  in  16  from FPU.
- fpu_overflow, fpu_underflow, fpu_inexact  in  1  from FPU.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accept.
- rsp_result  out  16  captured result.
- rsp_client  out  $clog2(NUM_CLIENTS)  granted client index.
- rsp_tag  out  TAG_W  echoed tag.
- rsp_flags  out  3  {overflow, underflow, inexact} of this op.
- sticky_flags  out  3  OR of rsp_flags since reset or clear.
- sticky_clear  in  1  clear sticky_flags.

Behaviour:
- States: IDLE, EXEC, RESP. Reset enters IDLE.
- Reset values: all registered outputs zero. This covers fpu_opA/opB/op, rsp_*, sticky_flags and the RR pointer (pointer = 0).
- Accept window: state IDLE, or state RESP with rsp_ready=1.
  - In the accept window, grant goes to the first valid client at or after the pointer, wrapping modulo NUM_CLIENTS.
  - req_ready[grant]=1 combinationally; all other bits 0. Outside the window req_ready=0.
- Handshake: req_valid&req_ready in cycle T.
  - Latch opA/opB/op/tag/client into the issue register.
  - Pointer becomes (grant+1) mod NUM_CLIENTS.
  - Next state EXEC.
- Requester rule: once req_valid is asserted, it and its payload stay stable until accepted. The block does not check this.
- EXEC (cycle T+1): fpu_* outputs are driven directly from the issue register. At the clock edge, capture fpu_result and the flags into the response register, then go to RESP. rsp_valid=1 from T+2.
- Latency: handshake to rsp_valid is exactly 2 cycles.
- RESP:
  - rsp_* held stable while rsp_ready=0.
  - On rsp_ready=1 with no new grant, go to IDLE; rsp_valid drops next cycle.
  - On rsp_ready=1 with a new grant, go straight to EXEC.
  - Sustained throughput: 1 op per 2 cycles.
- Between operations, fpu_* outputs hold their last issued values.
- No request valid in IDLE: stay in IDLE; the pointer does not move.
- Reset mid-EXEC or mid-RESP: the in-flight op is discarded and no response is produced.
- Sticky (when compiled in):
  - On each EXEC capture edge, sticky_flags <= (sticky_clear ? 0 : sticky_flags) | captured flags.
  - A clear in any other cycle zeros the register.
- NUM_CLIENTS=1 is illegal; use an elaboration-time assertion.

Optional Feature:
- Macro: FPU_STICKY_FLAGS_EN.
- Defined: sticky register behaves as above.
- Undefined: no register; sticky_flags tied to 0; sticky_clear ignored.
- rsp_flags is present in both builds.

Decomposition:
- Shared package fpu_pkg holds:
  - typedef fp16_t (logic [15:0]).
  - enum fpu_op_e: FPU_ADD=2'b00, FPU_SUB=2'b01, FPU_MUL=2'b10, FPU_DIV=2'b11.
  - struct fpu_flags_t {overflow, underflow, inexact}.
  - enum arb_state_e {IDLE, EXEC, RESP}.
- One natural sub-module: rr_arbiter (request vector, enable, pointer update, one-hot grant). Everything else stays inline.

Test Plan:
- Single add: client0 opA=3C00, opB=4000, op=00, tag=5, rsp_ready=1 -> rsp_valid exactly 2 cycles after handshake; rsp_result=4200, rsp_client=0, rsp_tag=5, rsp_flags=000.
- Contention: both clients valid continuously from reset -> grants go 0,1,0,1; each response carries the correct client index and tag.
- Backpressure: rsp_ready=0 for 5 cycles while client1 waits -> rsp fields stable, req_ready=00. Release -> client1 accepted in the same cycle as the rsp handshake; its response follows 2 cycles later.
- Overflow: 7BFF x 4000, op=10 -> rsp_flags[2]=1, sticky_flags=100. Then sticky_clear pulse in IDLE -> 000. Clear coincident with a capture carrying inexact -> 001.
- Reset mid-EXEC: assert reset the cycle after handshake -> rsp_valid never rises; outputs zero; pointer 0.
- Build without FPU_STICKY_FLAGS_EN: rerun the overflow case -> sticky_flags=000 throughout; rsp_flags unchanged.
